// File: rtl/st7735_driver.sv
// st7735_driver: SPI master that initialises an ST7735 panel from a fixed command ROM,
// then streams RGB565 pixels for the (x, y) coordinate it drives.
module st7735_driver #(
   parameter int HALF_PERIOD       = 2,
   parameter int RESET_LOW_CYCLES  = 1200000,
   parameter int RESET_WAIT_CYCLES = 1800000,
   parameter int SWRESET_WAIT      = 1800000,
   parameter int SLPOUT_WAIT       = 3000000,
   parameter int WIDTH             = 160,
   parameter int HEIGHT            = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] color,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic        oled_cs,
   output logic        oled_clk,
   output logic        oled_mosi,
   output logic        oled_dc,
   output logic        reset
);
   typedef enum logic [2:0] {HWRESET, RESET_WAIT, INIT, DELAY, STREAM} state_t;
   typedef enum logic [1:0] {P_IDLE, P_LOW, P_HIGH, P_GAP} phase_t;

   localparam int NROM = 18;
   localparam logic [15:0] HP1  = 16'(HALF_PERIOD - 1);
   localparam logic [31:0] RL1  = 32'(RESET_LOW_CYCLES - 1);
   localparam logic [31:0] RW1  = 32'(RESET_WAIT_CYCLES - 1);
   localparam logic [31:0] SW1  = 32'(SWRESET_WAIT - 1);
   localparam logic [31:0] SL1  = 32'(SLPOUT_WAIT - 1);
   localparam logic [7:0]  XMAX = 8'(WIDTH - 1);
   localparam logic [6:0]  YMAX = 7'(HEIGHT - 1);
   // entry = {post-delay select (1 = SWRESET, 2 = SLPOUT), dc, byte}
   localparam logic [10:0] ROM [NROM] = '{
      11'h201, 11'h411, 11'h03A, 11'h105, 11'h036, 11'h160,
      11'h02A, 11'h100, 11'h100, 11'h100, 11'h19F,
      11'h02B, 11'h100, 11'h100, 11'h100, 11'h17F,
      11'h029, 11'h02C
   };

   state_t      state_q, state_d;
   phase_t      ph_q, ph_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] tmr_q, tmr_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  sr_q, sr_d, lo_q, lo_d;
   logic [4:0]  idx_q, idx_d;
   logic [1:0]  dly_q, dly_d;
   logic        nxt_lo_q, nxt_lo_d;
   logic [7:0]  x_q, x_d;
   logic [6:0]  y_q, y_d;
   logic        cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d, dc_q, dc_d, prst_q, prst_d;
   logic        done, last, load, ld_dc;
   logic [7:0]  ld_byte;
   logic [10:0] ent;

   always_comb begin
      state_d  = state_q;
      ph_d     = ph_q;
      cnt_d    = cnt_q;
      tmr_d    = tmr_q;
      bit_d    = bit_q;
      sr_d     = sr_q;
      lo_d     = lo_q;
      idx_d    = idx_q;
      dly_d    = dly_q;
      nxt_lo_d = nxt_lo_q;
      x_d      = x_q;
      y_d      = y_q;
      cs_d     = cs_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      dc_d     = dc_q;
      prst_d   = prst_q;
      load     = 1'b0;
      ld_dc    = 1'b0;
      ld_byte  = '0;
      last     = 1'b0;
      ent      = '0;
      done     = ph_q == P_IDLE || (ph_q == P_GAP && cnt_q == '0);
      case (ph_q)
         P_LOW: begin
            sclk_d = cnt_q == '0;
            ph_d   = cnt_q == '0 ? P_HIGH : P_LOW;
            cnt_d  = cnt_q == '0 ? HP1 : cnt_q - 16'd1;
         end
         P_HIGH: begin
            if (cnt_q == '0) begin
               last   = bit_q == '0;
               sclk_d = 1'b0;
               cnt_d  = HP1;
               cs_d   = last;
               ph_d   = last ? P_GAP : P_LOW;
               bit_d  = bit_q - 3'd1;
               mosi_d = last ? mosi_q : sr_q[6];
               sr_d   = {sr_q[6:0], 1'b0};
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         P_GAP: cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 16'd1;
         default: ;
      endcase
      case (state_q)
         HWRESET: begin
            prst_d  = tmr_q == RL1;
            state_d = tmr_q == RL1 ? RESET_WAIT : HWRESET;
            tmr_d   = tmr_q == RL1 ? '0 : tmr_q + 32'd1;
         end
         RESET_WAIT: begin
            state_d = tmr_q == RW1 ? INIT : RESET_WAIT;
            tmr_d   = tmr_q == RW1 ? '0 : tmr_q + 32'd1;
         end
         INIT: begin
            if (done) begin
               if (dly_q != '0) begin
                  state_d = DELAY;
                  ph_d    = P_IDLE;
                  tmr_d   = '0;
               end else if (idx_q == 5'(NROM)) begin
                  state_d  = STREAM;
                  ph_d     = P_IDLE;
                  nxt_lo_d = 1'b0;
               end else begin
                  ent     = ROM[idx_q];
                  load    = 1'b1;
                  ld_dc   = ent[8];
                  ld_byte = ent[7:0];
                  dly_d   = ent[10:9];
                  idx_d   = idx_q + 5'd1;
               end
            end
         end
         DELAY: begin
            if (tmr_q == (dly_q == 2'd1 ? SW1 : SL1)) begin
               state_d = INIT;
               dly_d   = '0;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 32'd1;
            end
         end
         STREAM: begin
            // coordinate advances in the cs-high gap so the next colour is settled before sampling
            if (last && !nxt_lo_q) begin
               x_d = x_q == XMAX ? '0 : x_q + 8'd1;
               y_d = x_q != XMAX ? y_q : (y_q == YMAX ? '0 : y_q + 7'd1);
            end
            if (done) begin
               load     = 1'b1;
               ld_dc    = 1'b1;
               ld_byte  = nxt_lo_q ? lo_q : color[15:8];
               lo_d     = nxt_lo_q ? lo_q : color[7:0];
               nxt_lo_d = !nxt_lo_q;
            end
         end
         default: state_d = HWRESET;
      endcase
      if (load) begin
         cs_d   = 1'b0;
         dc_d   = ld_dc;
         mosi_d = ld_byte[7];
         sr_d   = ld_byte;
         bit_d  = 3'd7;
         ph_d   = P_LOW;
         cnt_d  = HP1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= HWRESET;
         ph_q     <= P_IDLE;
         cnt_q    <= '0;
         tmr_q    <= '0;
         bit_q    <= '0;
         sr_q     <= '0;
         lo_q     <= '0;
         idx_q    <= '0;
         dly_q    <= '0;
         nxt_lo_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         cs_q     <= 1'b1;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         dc_q     <= 1'b0;
         prst_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ph_q     <= ph_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         bit_q    <= bit_d;
         sr_q     <= sr_d;
         lo_q     <= lo_d;
         idx_q    <= idx_d;
         dly_q    <= dly_d;
         nxt_lo_q <= nxt_lo_d;
         x_q      <= x_d;
         y_q      <= y_d;
         cs_q     <= cs_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         dc_q     <= dc_d;
         prst_q   <= prst_d;
      end
   end

   assign x         = x_q;
   assign y         = y_q;
   assign oled_cs   = cs_q;
   assign oled_clk  = sclk_q;
   assign oled_mosi = mosi_q;
   assign oled_dc   = dc_q;
   assign reset     = prst_q;
endmodule

// File: tb/tb_st7735_driver.sv
// tb_st7735_driver: directed bench decoding the SPI byte stream of a shrunken st7735_driver.
module tb_st7735_driver;
   localparam int W = 32;
   localparam int H = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mode = 1'b0;
   logic [15:0] color;
   logic [7:0]  x;
   logic [6:0]  y;
   logic        oled_cs, oled_clk, oled_mosi, oled_dc, reset;

   st7735_driver #(
      .HALF_PERIOD(1), .RESET_LOW_CYCLES(10), .RESET_WAIT_CYCLES(10),
      .SWRESET_WAIT(10), .SLPOUT_WAIT(10), .WIDTH(W), .HEIGHT(H)
   ) dut (
      .clk(clk), .rst(rst), .color(color), .x(x), .y(y),
      .oled_cs(oled_cs), .oled_clk(oled_clk), .oled_mosi(oled_mosi),
      .oled_dc(oled_dc), .reset(reset)
   );

   always #5 clk = ~clk;

   assign color = mode ? ((x[3] ^ y[3]) ? 16'hA55A : 16'h1234) : 16'hF800;

   logic [8:0] bytes [$];
   int         bx [$];
   int         by [$];
   int         lens [$];
   int         rises [$];
   int         falls [$];
   int         total = 0;
   int         bad = 0;

   logic [8:0] exp_init [18] = '{
      9'h001, 9'h011, 9'h03A, 9'h105, 9'h036, 9'h160,
      9'h02A, 9'h100, 9'h100, 9'h100, 9'h19F,
      9'h02B, 9'h100, 9'h100, 9'h100, 9'h17F,
      9'h029, 9'h02C
   };

   // SPI decoder sampled on the falling clk edge, away from the DUT's update edge
   logic [7:0] sh;
   int         nb = 0, len = 0, cyc = 0;
   logic       sclk_p = 1'b0, cs_p = 1'b1;
   always @(negedge clk) begin
      if (rst) begin
         nb = 0;
         sclk_p = 1'b0;
         cs_p = 1'b1;
      end else begin
         if (oled_clk && !sclk_p) begin
            sh = {sh[6:0], oled_mosi};
            nb++;
            if (nb == 8) begin
               bytes.push_back({oled_dc, sh});
               bx.push_back(int'(x));
               by.push_back(int'(y));
               nb = 0;
            end
         end
         if (!oled_cs) len = cs_p ? 1 : len + 1;
         if (!oled_cs && cs_p) falls.push_back(cyc);
         if (oled_cs && !cs_p) begin
            lens.push_back(len);
            rises.push_back(cyc);
         end
         sclk_p = oled_clk;
         cs_p = oled_cs;
      end
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_bytes(input int n, input int lim);
      int c = 0;
      while (bytes.size() < n && c < lim) begin
         @(negedge clk);
         c++;
      end
      if (bytes.size() < n) check("timeout", bytes.size(), n);
   endtask

   initial begin
      int n, p, xe, ye, base, cmds;
      logic [15:0] ce;
      repeat (3) @(negedge clk);
      check("rst_cs", oled_cs, 1);
      check("rst_sclk", oled_clk, 0);
      check("rst_reset", reset, 0);
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      rst = 1'b0;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (reset) break;
      end
      check("reset_low_len", n, 10);
      wait_bytes(26, 3000);
      for (int i = 0; i < 18; i++) check($sformatf("init%0d", i), bytes[i], exp_init[i]);
      check("swreset_gap_ok", (falls[1] - rises[0]) >= 10, 1);
      check("len0", lens[0], 16);
      check("len3", lens[3], 16);
      check("len19", lens[19], 16);
      for (int i = 18; i < 26; i++) begin
         check($sformatf("red%0d", i), bytes[i], (i % 2 == 0) ? 9'h1F8 : 9'h100);
         check($sformatf("redx%0d", i), bx[i], (i - 18) / 2);
      end
      mode = 1'b1;
      wait_bytes(18 + 2 * (W * H + 4), 40000);
      cmds = 0;
      for (int i = 18; i < 18 + 2 * (W * H + 4); i++) if (!bytes[i][8]) cmds++;
      check("no_cmd_in_stream", cmds, 0);
      foreach (exp_init[k]) begin
         p = (k == 0) ? 20 : (k == 1) ? 47 : (k == 2) ? 300 : (k == 3) ? W * H - 1 :
             (k == 4) ? W * H : (k == 5) ? W * H + 1 : 0;
         if (k > 5) break;
         xe = p % W;
         ye = (p / W) % H;
         ce = (((xe >> 3) ^ (ye >> 3)) & 1) != 0 ? 16'hA55A : 16'h1234;
         check($sformatf("px%0d_x", p), bx[18 + 2 * p], xe);
         check($sformatf("px%0d_y", p), by[18 + 2 * p], ye);
         check($sformatf("px%0d_hi", p), bytes[18 + 2 * p], {1'b1, ce[15:8]});
         check($sformatf("px%0d_lo", p), bytes[19 + 2 * p], {1'b1, ce[7:0]});
      end
      n = 0;
      while (x == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("x_nonzero_before_rst", x != 0, 1);
      rst = 1'b1;
      #1;
      check("mid_cs", oled_cs, 1);
      check("mid_reset", reset, 0);
      check("mid_x", x, 0);
      check("mid_y", y, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base = bytes.size();
      wait_bytes(base + 2, 3000);
      check("replay0", bytes[base], 9'h001);
      check("replay1", bytes[base + 1], 9'h011);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/st7735_driver.md
Name: st7735_driver

Overview:
- SPI master that initialises an ST7735 160x128 TFT panel, then streams RGB565 pixels to it continuously.
- The parent supplies a colour combinationally from the (x, y) coordinate this block drives.
- Sits between pixel-generation logic (e.g. pattern generator) and the panel pins.

Parameters:
- HALF_PERIOD, 2: clk cycles per SPI clock half-period (>=1).
- RESET_LOW_CYCLES, 1200000: cycles the panel reset pin is held low after rst release.
- RESET_WAIT_CYCLES, 1800000: cycles waited after panel reset goes high, before the first command.
- SWRESET_WAIT, 1800000: cycles waited after SWRESET.
- SLPOUT_WAIT, 3000000: cycles waited after SLPOUT.
- WIDTH, 160: pixels per line.
- HEIGHT, 128: lines per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- color  in  16  RGB565 colour for pixel (x, y); R[15:11] G[10:5] B[4:0].
- x  out  8  column of pixel being sent, 0..WIDTH-1.
- y  out  7  row of pixel being sent, 0..HEIGHT-1.
- oled_cs  out  1  panel chip select, active low.
- oled_clk  out  1  SPI clock, mode 0, idle low.
- oled_mosi  out  1  SPI data, MSB first.
- oled_dc  out  1  0 = command byte, 1 = parameter/pixel byte.
- reset  out  1  panel hardware reset, active low.

Behaviour:
- Reset state while rst is high: oled_cs=1, oled_clk=0, oled_mosi=0, oled_dc=0, reset=0, x=0, y=0, FSM=HWRESET. The FSM is entered asynchronously.
- Byte transfer:
  - oled_cs goes low and oled_dc/oled_mosi are set up. Each bit is HALF_PERIOD cycles with oled_clk low (mosi valid) then HALF_PERIOD cycles with oled_clk high.
  - 8 bits are sent MSB first, so one byte takes 16*HALF_PERIOD cycles.
  - After the last high phase, oled_clk returns low and oled_cs goes high for HALF_PERIOD cycles before the next byte.
- FSM states: HWRESET -> RESET_WAIT -> INIT -> DELAY -> INIT ... -> STREAM.
  - HWRESET: reset=0 for RESET_LOW_CYCLES, then reset=1.
  - RESET_WAIT: idle for RESET_WAIT_CYCLES.
  - INIT: sends a fixed ROM sequence, listed below. Command bytes are sent with dc=0; parameter bytes with dc=1.
- Init ROM sequence:
  - 0x01 SWRESET, then wait SWRESET_WAIT.
  - 0x11 SLPOUT, then wait SLPOUT_WAIT.
  - 0x3A COLMOD, parameter 0x05 (16 bpp).
  - 0x36 MADCTL, parameter 0x60 (landscape, 160 columns).
  - 0x2A CASET, parameters 00 00 00 9F.
  - 0x2B RASET, parameters 00 00 00 7F.
  - 0x29 DISPON.
  - 0x2C RAMWR.
- STREAM:
  - Per pixel, sample color at the start of the high byte. Send color[15:8] then color[7:0], both with dc=1.
  - x and y hold the coordinate of the pixel being sent and are stable for its whole 2-byte transfer.
  - After the low byte completes, x increments. When x reaches WIDTH-1 it wraps to 0 and y increments. When y reaches HEIGHT-1 it also wraps to 0.
  - No further RAMWR is sent; the panel address window wraps automatically.
  - Streaming never stops until rst.
- Panel reset stays 1 from the end of HWRESET onward.
- rst asserted mid-operation aborts immediately to the reset state, and the full sequence repeats after release.
- color is read only at the sample point. Changes at other times do not affect the byte in flight.

Test Plan:
- Reset values: hold rst high, params set to small values (HALF_PERIOD=1, all waits=10). Required: cs=1, oled_clk=0, reset=0, x=0, y=0. After release, reset stays 0 for 10 cycles, then goes to 1.
- Init decode: capture bytes on oled_clk rising edges while cs=0, tagged with dc. Required order: C01, C11, C3A D05, C36 D60, C2A D00 D00 D00 D9F, C2B D00 D00 D00 D7F, C29, C2C.
- Init timing: gap between the end of SWRESET and the start of SLPOUT is at least SWRESET_WAIT cycles. Each byte lasts 16*HALF_PERIOD cycles with cs low.
- Pixel stream: color=0xF800 constant. Required: bytes 0xF8, 0x00 repeated with dc=1. x steps 0,1,2,... once every two bytes.
- Wrap: run to x=159, y=127. The next pixel is x=0, y=0 and no command byte is sent. A color driven from x[3]^y[3] yields a checkerboard byte pattern matching the coordinates.
- Mid-stream rst: pulse rst during pixel streaming. Required: cs=1, reset=0, x=y=0 immediately, and the init sequence replays from C01.
